// File: rtl/instr_fetch_if.sv
// instr_fetch_if: imem read bus (mem_req/addr/ack/rdata) and decode handshake (id_valid/ready/instr/pc/pc_plus1); master = fetch stage
interface instr_fetch_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_rdata;
  logic              id_valid;
  logic              id_ready;
  logic [DATA_W-1:0] id_instr;
  logic [ADDR_W-1:0] id_pc;
  logic [ADDR_W-1:0] id_pc_plus1;
  modport master (
    output mem_req, mem_addr, id_valid, id_instr, id_pc, id_pc_plus1,
    input  mem_ack, mem_rdata, id_ready
  );
  modport slave (
    input  mem_req, mem_addr, id_valid, id_instr, id_pc, id_pc_plus1,
    output mem_ack, mem_rdata, id_ready
  );
endinterface

// File: rtl/instr_fetch.sv
// instr_fetch: reads imem at the PC, buffers {instr, pc, pc+1} in a 2-entry FIFO for decode, holds the PC via fetch_halt until a fetch is accepted
// ports: clk, rst (async, active-high); instr_address/instr_address_plus1 and flush from the PC side; fetch_halt to pc.halt;
//        bus (instr_fetch_if.master) carries the imem read bus and the decode valid/ready handshake;
//        IFETCH_PERF_EN adds perf_fetches/perf_stalls counters
module instr_fetch #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] instr_address,
  input  logic [ADDR_W-1:0] instr_address_plus1,
  input  logic              flush,
  output logic              fetch_halt,
`ifdef IFETCH_PERF_EN
  output logic [31:0]       perf_fetches,
  output logic [31:0]       perf_stalls,
`endif
  instr_fetch_if.master     bus
);
  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} state_t;
  typedef struct packed {
    logic [DATA_W-1:0] instr;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] pc_plus1;
  } entry_t;
  state_t state, state_n;
  entry_t slot [2];
  logic push, pop, wr;
  assign bus.mem_req = (state != FULL) & ~flush & ~rst;
  assign bus.mem_addr = instr_address;
  assign bus.id_valid = state != EMPTY;
  assign {bus.id_instr, bus.id_pc, bus.id_pc_plus1} = slot[0];
  assign push = bus.mem_req & bus.mem_ack;
  assign pop = bus.id_valid & bus.id_ready & ~flush;
  assign wr = (state == ONE) & ~pop;
  assign fetch_halt = ~push;
  always_comb begin
    state_n = flush ? EMPTY
            : (push & ~pop) ? ((state == EMPTY) ? ONE : FULL)
            : (pop & ~push) ? ((state == FULL) ? ONE : EMPTY)
            : state;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= EMPTY;
    else state <= state_n;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      slot[0] <= '0;
      slot[1] <= '0;
    end else begin
      if (pop & (state == FULL)) slot[0] <= slot[1];
      if (push) slot[wr] <= {bus.mem_rdata, instr_address, instr_address_plus1};
    end
`ifdef IFETCH_PERF_EN
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      perf_fetches <= '0;
      perf_stalls <= '0;
    end else begin
      perf_fetches <= perf_fetches + 32'(push);
      perf_stalls <= perf_stalls + 32'(bus.mem_req & ~bus.mem_ack);
    end
`endif
endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: randomized scoreboard bench for instr_fetch with a PC/memory environment model
module tb_instr_fetch;
  logic clk = 0, rst = 0, flush = 0, fetch_halt, acc = 0, exp_req = 0;
  logic [31:0] pc, flush_target = 0;
  typedef struct {logic [31:0] instr; logic [31:0] pc;} exp_t;
  exp_t q[$];
  exp_t pend_e;
  logic pend_push = 0, pend_flush = 0, force_flush = 0;
  int ack_wait = 0, wait_n = 0;
  int unsigned ready_pct = 100, flush_pct = 0, fetches_m = 0, stalls_m = 0;
  int vectors = 0, miscompares = 0;
  instr_fetch_if #(.ADDR_W(32), .DATA_W(32)) bus ();
`ifdef IFETCH_PERF_EN
  logic [31:0] perf_fetches, perf_stalls;
`endif
  instr_fetch #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk),
    .rst(rst),
    .instr_address(pc),
    .instr_address_plus1(pc + 32'd1),
    .flush(flush),
    .fetch_halt(fetch_halt),
`ifdef IFETCH_PERF_EN
    .perf_fetches(perf_fetches),
    .perf_stalls(perf_stalls),
`endif
    .bus(bus)
  );
  always #5 clk = ~clk;
  always @(posedge clk or posedge rst)
    if (rst) pc <= 0;
    else if (flush) pc <= flush_target;
    else if (acc) pc <= pc + 1;
  function automatic logic [31:0] f(input logic [31:0] a);
    return 32'hA000_0000 + a;
  endfunction
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, want %h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic step();
    @(posedge clk);
    if (pend_flush) q.delete();
    else if (pend_push) q.push_back(pend_e);
    #1;
`ifdef IFETCH_PERF_EN
    check("perf_fetches", perf_fetches, fetches_m);
    check("perf_stalls", perf_stalls, stalls_m);
`endif
    flush = force_flush | (flush_pct != 0 && $urandom_range(99) < flush_pct);
    flush_target = force_flush ? 32'h40 : 32'($urandom_range(255));
    bus.id_ready = $urandom_range(99) < ready_pct;
    exp_req = q.size() < 2 && !flush;
    bus.mem_ack = exp_req && (ack_wait < 0 ? $urandom_range(1) == 1 : wait_n >= ack_wait);
    bus.mem_rdata = exp_req ? f(pc) : $urandom;
    #1;
    check("mem_req", bus.mem_req, exp_req);
    if (exp_req) check("mem_addr", bus.mem_addr, pc);
    check("fetch_halt", fetch_halt, !(exp_req && bus.mem_ack));
    acc = exp_req && bus.mem_ack;
    pend_push = acc;
    pend_e = '{f(pc), pc};
    pend_flush = flush;
    wait_n = (exp_req && !bus.mem_ack) ? wait_n + 1 : 0;
    if (acc) fetches_m++;
    if (exp_req && !bus.mem_ack) stalls_m++;
  endtask
  task automatic check_reset_outputs();
    check("rst_mem_req", bus.mem_req, 0);
    check("rst_fetch_halt", fetch_halt, 1);
    check("rst_id_valid", bus.id_valid, 0);
    check("rst_id_instr", bus.id_instr, 0);
    check("rst_id_pc", bus.id_pc, 0);
    check("rst_id_pc_plus1", bus.id_pc_plus1, 0);
  endtask
  always @(negedge clk)
    if (!rst) begin
      check("id_valid", bus.id_valid, q.size() != 0);
      if (q.size() != 0) begin
        check("id_instr", bus.id_instr, q[0].instr);
        check("id_pc", bus.id_pc, q[0].pc);
        check("id_pc_plus1", bus.id_pc_plus1, q[0].pc + 32'd1);
        if (bus.id_ready) void'(q.pop_front());
      end
    end
  initial begin
    bus.mem_ack = 0;
    bus.mem_rdata = 0;
    bus.id_ready = 0;
    #1 rst = 1;
    #1 check_reset_outputs();
    @(negedge clk);
    #1 rst = 0;
    ack_wait = 0; ready_pct = 100;
    repeat (20) step();
    ack_wait = 3;
    repeat (24) step();
    ack_wait = 0; ready_pct = 0;
    repeat (6) step();
    ready_pct = 100;
    repeat (6) step();
    ready_pct = 0;
    repeat (4) step();
    force_flush = 1;
    step();
    force_flush = 0; ready_pct = 100;
    repeat (6) step();
    ack_wait = -1; ready_pct = 60; flush_pct = 8;
    repeat (2000) step();
    ack_wait = 0; ready_pct = 0; flush_pct = 0;
    repeat (4) step();
    #1 rst = 1;
    #1 check_reset_outputs();
    q.delete();
    pend_push = 0; pend_flush = 0; acc = 0; flush = 0;
    wait_n = 0; fetches_m = 0; stalls_m = 0;
    @(negedge clk);
    #1 rst = 0;
    ack_wait = 2; ready_pct = 100;
    repeat (30) step();
    @(posedge clk);
    #1;
`ifdef IFETCH_PERF_EN
    check("perf_fetches_10", perf_fetches, 10);
    check("perf_stalls_20", perf_stalls, 20);
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
